// File: rtl/uart_if.sv
// -----------------------------------------------------------------------------
// uart_if: bundles the UART host-side handshake and the serial pins.
//   tx_start, tx_data  -> core : transmit request and payload
//   tx_busy, tx_done   <- core : transmit status
//   txd                <- core : serial output pin
//   rxd                -> core : serial input pin (asynchronous)
//   rx_data, rx_valid,
//   rx_frame_err,
//   rx_parity_err      <- core : receive result and error flags
// Modports: slave = the UART core, master = the logic driving it.
// -----------------------------------------------------------------------------
interface uart_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 txd;
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_parity_err;

    modport slave (
        input  tx_start, tx_data, rxd,
        output tx_busy, tx_done, txd, rx_data, rx_valid, rx_frame_err, rx_parity_err
    );

    modport master (
        output tx_start, tx_data, rxd,
        input  tx_busy, tx_done, txd, rx_data, rx_valid, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core: parametrised full-duplex UART.
//   Configurable payload width, parity (none/even/odd), 1 or 2 stop bits and
//   baud divisor. One free-running oversample tick generator (16 ticks per bit)
//   is shared by TX and RX. RX uses a 2-flop synchroniser, majority vote of the
//   samples at ticks 7/8/9 and reports framing and parity errors.
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   loopback  (only with UART_LOOPBACK_EN) RX takes internal txd, pin txd held 1
//   bus       uart_if.slave: tx_start/tx_data/tx_busy/tx_done/txd,
//             rxd/rx_data/rx_valid/rx_frame_err/rx_parity_err
// Optional feature macro: UART_LOOPBACK_EN
// -----------------------------------------------------------------------------
module uart_core #(
    parameter int BAUD_DIV  = 651,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic  clk,
    input  logic  reset_n,
`ifdef UART_LOOPBACK_EN
    input  logic  loopback,
`endif
    uart_if.slave bus
);
    localparam int   DIV_W   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int   BIT_W   = $clog2(DATA_BITS);
    localparam logic PAR_EN  = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY == 2);

    // ---------------------------------------------------------------- ticks
    logic [DIV_W-1:0] br_cnt;
    logic             br_tick;

    assign br_tick = (br_cnt == DIV_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     br_cnt <= '0;
        else if (br_tick) br_cnt <= '0;
        else              br_cnt <= br_cnt + 1'b1;
    end

    // ---------------------------------------------------------- rxd sync
    logic [1:0] rxd_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rxd_sync <= 2'b11;
        else          rxd_sync <= {rxd_sync[0], bus.rxd};
    end

    // ------------------------------------------------------------------ TX
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t            tx_state, tx_state_n;
    logic [DATA_BITS-1:0] tx_shreg, tx_shreg_n;
    logic [3:0]           tx_tick, tx_tick_n;
    logic [BIT_W-1:0]     tx_bit, tx_bit_n;
    logic                 tx_stop, tx_stop_n;
    logic                 tx_par, tx_par_n;
    logic                 txd_q, txd_n;
    logic                 tx_done_q, tx_done_n;
    logic                 tx_last;

    // Last oversample tick of the current bit cell.
    assign tx_last = br_tick && (tx_tick == 4'd15);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state  <= TX_IDLE;
            tx_shreg  <= '0;
            tx_tick   <= '0;
            tx_bit    <= '0;
            tx_stop   <= 1'b0;
            tx_par    <= 1'b0;
            txd_q     <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_shreg  <= tx_shreg_n;
            tx_tick   <= tx_tick_n;
            tx_bit    <= tx_bit_n;
            tx_stop   <= tx_stop_n;
            tx_par    <= tx_par_n;
            txd_q     <= txd_n;
            tx_done_q <= tx_done_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_shreg_n = tx_shreg;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_stop_n  = tx_stop;
        tx_par_n   = tx_par;
        tx_done_n  = 1'b0;
        txd_n      = 1'b1;

        if (tx_state != TX_IDLE && br_tick) tx_tick_n = tx_tick + 4'd1;

        case (tx_state)
            TX_IDLE: begin
                if (bus.tx_start) begin
                    tx_shreg_n = bus.tx_data;
                    tx_par_n   = (^bus.tx_data) ^ PAR_ODD;
                    tx_tick_n  = '0;
                    tx_bit_n   = '0;
                    tx_stop_n  = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: if (tx_last) tx_state_n = TX_DATA;
            TX_DATA: begin
                if (tx_last) begin
                    tx_shreg_n = tx_shreg >> 1;
                    if (tx_bit == BIT_W'(DATA_BITS - 1))
                        tx_state_n = PAR_EN ? TX_PARITY : TX_STOP;
                    else
                        tx_bit_n = tx_bit + 1'b1;
                end
            end
            TX_PARITY: if (tx_last) tx_state_n = TX_STOP;
            TX_STOP: begin
                if (tx_last) begin
                    if (tx_stop == 1'(STOP_BITS - 1)) begin
                        tx_state_n = TX_IDLE;
                        tx_done_n  = 1'b1;
                    end else begin
                        tx_stop_n = 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        // txd is registered from the next state so the pin never glitches.
        case (tx_state_n)
            TX_START:  txd_n = 1'b0;
            TX_DATA:   txd_n = tx_shreg_n[0];
            TX_PARITY: txd_n = tx_par_n;
            default:   txd_n = 1'b1;
        endcase
    end

    assign bus.tx_busy = (tx_state != TX_IDLE);
    assign bus.tx_done = tx_done_q;
`ifdef UART_LOOPBACK_EN
    assign bus.txd     = loopback ? 1'b1 : txd_q;
`else
    assign bus.txd     = txd_q;
`endif

    // ------------------------------------------------------------------ RX
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t            rx_state, rx_state_n;
    logic [DATA_BITS-1:0] rx_shreg, rx_shreg_n;
    logic [3:0]           rx_tick, rx_tick_n;
    logic [BIT_W-1:0]     rx_bit, rx_bit_n;
    logic                 rx_s7, rx_s7_n, rx_s8, rx_s8_n;
    logic                 rx_acc, rx_acc_n;      // running XOR of received payload
    logic                 rx_pend, rx_pend_n;    // parity mismatch awaiting stop bit
    logic                 rx_prev;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_n;
    logic                 rx_valid_q, rx_valid_n;
    logic                 rx_fe_q, rx_fe_n;
    logic                 rx_pe_q, rx_pe_n;
    logic                 rx_in, rx_samp, rx_end, rx_maj;

`ifdef UART_LOOPBACK_EN
    // Source select only changes between frames so a frame is never split.
    logic lb_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                lb_sel <= 1'b0;
        else if (rx_state == RX_IDLE) lb_sel <= loopback;
    end

    assign rx_in = lb_sel ? txd_q : rxd_sync[1];
`else
    assign rx_in = rxd_sync[1];
`endif

    assign rx_samp = br_tick && (rx_tick == 4'd9);
    assign rx_end  = br_tick && (rx_tick == 4'd15);
    assign rx_maj  = (rx_s7 & rx_s8) | (rx_s7 & rx_in) | (rx_s8 & rx_in);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= RX_IDLE;
            rx_shreg   <= '0;
            rx_tick    <= '0;
            rx_bit     <= '0;
            rx_s7      <= 1'b1;
            rx_s8      <= 1'b1;
            rx_acc     <= 1'b0;
            rx_pend    <= 1'b0;
            rx_prev    <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_fe_q    <= 1'b0;
            rx_pe_q    <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_shreg   <= rx_shreg_n;
            rx_tick    <= rx_tick_n;
            rx_bit     <= rx_bit_n;
            rx_s7      <= rx_s7_n;
            rx_s8      <= rx_s8_n;
            rx_acc     <= rx_acc_n;
            rx_pend    <= rx_pend_n;
            rx_prev    <= rx_in;
            rx_data_q  <= rx_data_n;
            rx_valid_q <= rx_valid_n;
            rx_fe_q    <= rx_fe_n;
            rx_pe_q    <= rx_pe_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_shreg_n = rx_shreg;
        rx_tick_n  = rx_tick;
        rx_bit_n   = rx_bit;
        rx_s7_n    = rx_s7;
        rx_s8_n    = rx_s8;
        rx_acc_n   = rx_acc;
        rx_pend_n  = rx_pend;
        rx_data_n  = rx_data_q;
        rx_valid_n = 1'b0;
        rx_fe_n    = rx_fe_q;
        rx_pe_n    = rx_pe_q;

        if (rx_state != RX_IDLE && br_tick) begin
            rx_tick_n = rx_tick + 4'd1;
            if (rx_tick == 4'd7) rx_s7_n = rx_in;
            if (rx_tick == 4'd8) rx_s8_n = rx_in;
        end

        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_in) begin
                    rx_tick_n  = '0;
                    rx_bit_n   = '0;
                    rx_acc_n   = 1'b0;
                    rx_pend_n  = 1'b0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_samp && rx_maj) rx_state_n = RX_IDLE;   // glitch, not a start bit
                else if (rx_end)       rx_state_n = RX_DATA;
            end
            RX_DATA: begin
                if (rx_samp) begin
                    rx_shreg_n = {rx_maj, rx_shreg[DATA_BITS-1:1]};
                    rx_acc_n   = rx_acc ^ rx_maj;
                end
                if (rx_end) begin
                    if (rx_bit == BIT_W'(DATA_BITS - 1))
                        rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
                    else
                        rx_bit_n = rx_bit + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_samp) rx_pend_n = rx_maj ^ rx_acc ^ PAR_ODD;
                if (rx_end)  rx_state_n = RX_STOP;
            end
            RX_STOP: begin
                // Finish at the majority point so a following start bit is not missed.
                if (rx_samp) begin
                    rx_data_n  = rx_shreg;
                    rx_valid_n = 1'b1;
                    rx_fe_n    = ~rx_maj;
                    rx_pe_n    = PAR_EN & rx_pend;
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_frame_err  = rx_fe_q;
    assign bus.rx_parity_err = rx_pe_q;

endmodule

// File: tb/tb_uart_core.sv
// -----------------------------------------------------------------------------
// tb_uart_core: directed bench for uart_core with BAUD_DIV=4 (64 clk per bit).
//   u0: 8N1      - TX waveform, RX framing error, glitch rejection, loopback
//   u1: 7E1      - RX parity good / bad
//   u2: 8N2      - back-to-back TX and mid-frame reset (own reset)
// -----------------------------------------------------------------------------
module tb_uart_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst2_n;
    logic [2:0] rxd_v;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    // Edge index since reset release; the baud counter runs in step with it.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    uart_if #(.DATA_BITS(8)) if0 ();
    uart_if #(.DATA_BITS(7)) if1 ();
    uart_if #(.DATA_BITS(8)) if2 ();

    assign if0.rxd = rxd_v[0];
    assign if1.rxd = rxd_v[1];
    assign if2.rxd = rxd_v[2];

`ifdef UART_LOOPBACK_EN
    logic lb0;
`endif

    uart_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset_n(rst_n),
`ifdef UART_LOOPBACK_EN
        .loopback(lb0),
`endif
        .bus(if0.slave));

    uart_core #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset_n(rst_n),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .bus(if1.slave));

    uart_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset_n(rst2_n),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .bus(if2.slave));

    // RX result capture
    int         rxv [2] = '{0, 0};
    logic [7:0] cap_d [2];
    logic       cap_fe [2];
    logic       cap_pe [2];

    always @(negedge clk) begin
        if (if0.rx_valid) begin
            rxv[0]    <= rxv[0] + 1;
            cap_d[0]  <= if0.rx_data;
            cap_fe[0] <= if0.rx_frame_err;
            cap_pe[0] <= if0.rx_parity_err;
        end
        if (if1.rx_valid) begin
            rxv[1]    <= rxv[1] + 1;
            cap_d[1]  <= {1'b0, if1.rx_data};
            cap_fe[1] <= if1.rx_frame_err;
            cap_pe[1] <= if1.rx_parity_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int idx, input logic b);
        rxd_v[idx] = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_rx(input int idx, input logic [7:0] d, input int nb,
                           input bit hp, input logic pb, input logic sb);
        @(negedge clk);
        put(idx, 1'b0);
        for (int i = 0; i < nb; i++) put(idx, d[i]);
        if (hp) put(idx, pb);
        put(idx, sb);
        rxd_v[idx] = 1'b1;
    endtask

    task automatic rx_case(input string tag, input int idx, input logic [7:0] d, input int nb,
                           input bit hp, input logic pb, input logic sb,
                           input logic [7:0] ed, input logic efe, input logic epe);
        int base;
        int n;
        base = rxv[idx];
        n = 0;
        send_rx(idx, d, nb, hp, pb, sb);
        while (rxv[idx] == base && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_cnt"}, rxv[idx] - base, 1);
        chk({tag, "_data"}, cap_d[idx], ed);
        chk({tag, "_fe"}, cap_fe[idx], efe);
        chk({tag, "_pe"}, cap_pe[idx], epe);
    endtask

    // Leaves the bench at a negedge whose following posedge is a baud-tick edge.
    task automatic align_tick();
        @(negedge clk);
        while (cyc % 4 != 3) @(negedge clk);
    endtask

    logic [9:0] a5_bits;
    logic [6:0] d35;
    int         busy_n, done_at, dcnt, wave_err, fall2, base, pin_low;
    logic       txd_pre;

    initial begin
        a5_bits = 10'b11010_01010;   // stop,d7..d0,start read MSB..LSB: 1,1,0,1,0,0,1,0,1,0
        d35 = 7'h35;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        rxd_v = 3'b111;
        if0.tx_start = 1'b0; if0.tx_data = '0;
        if1.tx_start = 1'b0; if1.tx_data = '0;
        if2.tx_start = 1'b0; if2.tx_data = '0;
`ifdef UART_LOOPBACK_EN
        lb0 = 1'b0;
`endif
        repeat (5) @(negedge clk);
        chk("rst_txd", if0.txd, 1);
        chk("rst_busy", if0.tx_busy, 0);
        chk("rst_done", if0.tx_done, 0);
        chk("rst_rx_data", if0.rx_data, 0);
        chk("rst_rx_valid", if0.rx_valid, 0);
        chk("rst_fe", if0.rx_frame_err, 0);
        chk("rst_pe", if0.rx_parity_err, 0);
        chk("rst_txd2", if2.txd, 1);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        repeat (10) @(negedge clk);

        // --- 8N1 transmit of 0xA5
        align_tick();
        if0.tx_data = 8'hA5;
        if0.tx_start = 1'b1;
        @(negedge clk);
        if0.tx_start = 1'b0;
        busy_n = 0; done_at = -1; dcnt = 0; wave_err = 0;
        for (int n = 0; n < 720; n++) begin
            if (n > 0) @(negedge clk);
            if (if0.tx_busy) busy_n++;
            if (if0.tx_done) begin
                dcnt++;
                if (done_at < 0) done_at = n;
            end
            if (n < 640 && if0.txd !== a5_bits[n/64]) wave_err++;
            if (n < 640 && n % 64 == 32) chk($sformatf("tx_a5_bit%0d", n/64), if0.txd, a5_bits[n/64]);
        end
        chk("tx_a5_wave_err", wave_err, 0);
        chk("tx_a5_busy_clk", busy_n, 640);
        chk("tx_a5_done_at", done_at, 640);
        chk("tx_a5_done_cnt", dcnt, 1);

        // --- 7E1 receive, correct and flipped parity
        rx_case("rx_par_ok", 1, {1'b0, d35}, 7, 1'b1, ^d35, 1'b1, 8'h35, 1'b0, 1'b0);
        rx_case("rx_par_bad", 1, {1'b0, d35}, 7, 1'b1, ~(^d35), 1'b1, 8'h35, 1'b0, 1'b1);

        // --- 8N1 receive with stop bit low
        rx_case("rx_frame", 0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);

        // --- 3-clk glitch on idle line
        repeat (20) @(negedge clk);
        base = rxv[0];
        rxd_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rxd_v[0] = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_no_valid", rxv[0] - base, 0);
        chk("glitch_rx_hold", if0.rx_data, 8'h3C);
        rx_case("rx_55", 0, 8'h55, 8, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);

        // --- 8N2 back-to-back, tx_start held high
        align_tick();
        if2.tx_data = 8'hFF;
        if2.tx_start = 1'b1;
        @(negedge clk);
        if2.tx_data = 8'h00;
        busy_n = 0; done_at = -1; dcnt = 0; wave_err = 0; fall2 = -1; txd_pre = 1'b1;
        for (int n = 0; n <= 1005; n++) begin
            if (n > 0) @(negedge clk);
            if (n < 704 && if2.tx_busy) busy_n++;
            if (n < 704 && if2.txd !== ((n < 64) ? 1'b0 : 1'b1)) wave_err++;
            if (if2.tx_done) begin
                dcnt++;
                if (done_at < 0) done_at = n;
            end
            if (done_at >= 0 && fall2 < 0 && !if2.txd) fall2 = n;
            if (n == 704) chk("b2b_busy_fall", if2.tx_busy, 0);
            if (n == 705) chk("b2b_busy_rise", if2.tx_busy, 1);
            txd_pre = if2.txd;
        end
        chk("b2b_wave_err", wave_err, 0);
        chk("b2b_busy_clk", busy_n, 704);
        chk("b2b_done_at", done_at, 704);
        chk("b2b_start2_at", fall2, 705);
        chk("b2b_txd_before_rst", txd_pre, 0);
        rst2_n = 1'b0;
        if2.tx_start = 1'b0;
        #1;
        chk("rst_mid_txd", if2.txd, 1);
        chk("rst_mid_busy", if2.tx_busy, 0);
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if (if2.tx_done) dcnt++;
        end
        chk("rst_mid_done_cnt", dcnt, 1);
        chk("rst_mid_txd_idle", if2.txd, 1);

`ifdef UART_LOOPBACK_EN
        // --- internal loopback of 0x5A
        lb0 = 1'b1;
        repeat (8) @(negedge clk);
        base = rxv[0];
        pin_low = 0;
        if0.tx_data = 8'h5A;
        if0.tx_start = 1'b1;
        @(negedge clk);
        if0.tx_start = 1'b0;
        for (int n = 0; n < 720; n++) begin
            @(negedge clk);
            if (!if0.txd) pin_low++;
        end
        chk("lb_pin_low", pin_low, 0);
        chk("lb_cnt", rxv[0] - base, 1);
        chk("lb_data", cap_d[0], 8'h5A);
        chk("lb_fe", cap_fe[0], 0);
        chk("lb_pe", cap_pe[0], 0);
`else
        pin_low = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART. Successor to the fixed 8N1 UART.
- Adds configurable data width, parity, stop-bit count and baud divisor.
- Receiver uses mid-bit majority-vote sampling and reports framing and parity errors.
- Sits between the board RX/TX pins and the command/counter logic; one shared baud tick generator.

Parameters:
- BAUD_DIV, 651, system clocks per oversample tick (100 MHz / 9600 / 16); minimum legal value 2.
- DATA_BITS, 8, payload bits per frame; legal 5..8; sent and received LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset; one clock domain only.
- tx_start  in  1  request to transmit tx_data; sampled only when tx_busy=0.
- tx_data  in  DATA_BITS  transmit payload; captured on an accepted tx_start.
- tx_busy  out  1  high from the cycle after acceptance until the last stop bit completes.
- tx_done  out  1  one-clock pulse at the end of the last stop bit.
- txd  out  1  serial output; idles high.
- rxd  in  1  serial input; asynchronous to clk.
- rx_data  out  DATA_BITS  last received payload; held until the next frame completes.
- rx_valid  out  1  one-clock pulse when a frame ends, errors or not.
- rx_frame_err  out  1  valid with rx_valid; first stop bit sampled low.
- rx_parity_err  out  1  valid with rx_valid; parity mismatch; always 0 when PARITY=0.

Behaviour:
- Reset values: txd=1, tx_busy=0, tx_done=0, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0. All counters cleared and both FSMs go to IDLE.
- Reset is asynchronous; asserting it mid-frame aborts the frame immediately, with no done or valid pulse.
- Tick generator:
  - counter 0..BAUD_DIV-1;
  - br_tick is a one-clock pulse when the counter wraps;
  - free-running, shared by TX and RX;
  - 16 ticks per bit.
- Input sync: rxd passes through a 2-flop synchroniser before any use; it is reset to 1.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: txd=1. On tx_start=1, latch tx_data into a shift register, clear counters and go to START. tx_busy rises the next cycle.
  - START, DATA, PARITY and STOP each last 16 br_ticks.
  - DATA shifts right each bit; bit counter runs 0..DATA_BITS-1.
  - PARITY state is present only when PARITY!=0. It sends the XOR of the payload (even), or its inverse (odd).
  - STOP lasts STOP_BITS x 16 ticks.
  - On the final tick: tx_done pulses, tx_busy falls and the FSM returns to IDLE. A tx_start in that same cycle is ignored; it is accepted one cycle later in IDLE.
  - tx_start while busy is ignored, and tx_data changes while busy have no effect.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a falling edge on synchronised rxd clears the tick counter and goes to START.
  - Bit value is the majority of the samples at ticks 7, 8 and 9 within each bit.
  - START: if the majority is 1 (glitch), return to IDLE with no rx_valid.
  - DATA: shift the majority value into the MSB of a DATA_BITS register; after DATA_BITS bits the register holds the payload LSB first.
  - PARITY: compare against recomputed parity.
  - STOP: check only the first stop bit. After its majority point (tick 9), update rx_data, pulse rx_valid and load both error flags, then return to IDLE. It does not wait for the remaining stop ticks, so back-to-back frames are tolerated.
  - A second stop bit is never checked.
  - Error flags hold their value until the next rx_valid.
- Latency: tx_start accept -> txd falls at 1 clk. rx_valid occurs 10 ticks into the first stop bit (+2 clk for the synchroniser).
- TX and RX are fully independent; simultaneous activity is legal.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the RX path takes txd internally instead of synchronised rxd, and txd is held at 1 on the pin. Switching loopback takes effect only while RX is in IDLE.
- Undefined: no loopback port; RX always uses rxd.

Test Plan:
- BAUD_DIV=4, 8N1: tx_start with tx_data=0xA5 -> txd shows 0, 1,0,1,0,0,1,0,1, 1, each 64 clk. tx_done pulses once at 640 clk; tx_busy is high for 640 clk.
- BAUD_DIV=4, PARITY=1, DATA_BITS=7: drive rxd frame 0x35 with correct parity bit -> rx_data=0x35, rx_valid 1 clk, both errors 0. Repeat with the parity bit flipped -> rx_parity_err=1.
- Stop bit driven 0 on received 0x3C -> rx_valid with rx_frame_err=1, rx_data=0x3C.
- 3-clk low glitch on idle rxd -> no rx_valid, RX returns to IDLE, and the next valid frame 0x55 is received correctly.
- STOP_BITS=2: send 0xFF then 0x00 back-to-back; tx_start asserted continuously -> second start bit begins 1 clk after tx_done, frame length 704 clk. reset_n pulsed mid-second-frame -> txd=1 immediately, no tx_done.
- UART_LOOPBACK_EN, loopback=1: transmit 0x5A -> rx_valid with rx_data=0x5A, no errors, pin txd stays 1.
